// File: rtl/pll_reset_sequencer_if.sv
// Control/status bundle between the PLL reset sequencer and its environment.
// slave: sequencer side (lock/relock in, resets/status out); master: environment side.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    modport master (
        output pll_locked, relock_req,
        input  pll_rst, sys_reset, ready, fault,
        input  retry_count, lock_loss_count
    );

    modport slave (
        input  pll_locked, relock_req,
        output pll_rst, sys_reset, ready, fault,
        output retry_count, lock_loss_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for lock with timeout/retry,
// qualifies lock, releases sys_reset, re-sequences on lock loss or relock_req.
// Ports: refclk, rst_n (async active-low), bus (slave modport):
//   in  pll_locked (async), relock_req
//   out pll_rst, sys_reset, ready, fault, retry_count[3:0], lock_loss_count[7:0]
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.slave  bus
);
    localparam int unsigned M1 = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                 RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX = (M1 > LOCK_STABLE_CYCLES) ?
                                      M1 : LOCK_STABLE_CYCLES;
    // cnt only ever reaches CNT_MAX-1
    localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          locked_s;
    logic          clr;
    logic [3:0]    retry_d;
    logic [7:0]    llc_d;

    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        retry_d = bus.retry_count;
        llc_d   = bus.lock_loss_count;
        unique case (state_q)
            RESET_PLL: begin
                if (bus.relock_req) begin
                    clr = 1'b1;
                end else if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    clr     = 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (bus.relock_req) begin
                    state_d = RESET_PLL;
                    clr     = 1'b1;
                end else if (locked_s) begin
                    state_d = STABLE;
                    clr     = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    clr = 1'b1;
                    if (bus.retry_count == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RESET_PLL;
                        retry_d = bus.retry_count + 4'd1;
                    end
                end
            end
            STABLE: begin
                if (bus.relock_req) begin
                    state_d = RESET_PLL;
                    clr     = 1'b1;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    clr     = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    clr     = 1'b1;
                    retry_d = 4'd0;
                end
            end
            RUN: begin
                // cnt is idle here; hold it at zero
                clr = 1'b1;
                if (bus.relock_req) begin
                    state_d = RESET_PLL;
                end else if (!locked_s) begin
                    state_d = RESET_PLL;
                    if (bus.lock_loss_count != 8'hFF) begin
                        llc_d = bus.lock_loss_count + 8'd1;
                    end
                end
            end
            FAULT: begin
                clr = 1'b1;
                if (bus.relock_req) begin
                    state_d = RESET_PLL;
                    retry_d = 4'd0;
                end
            end
            default: begin
                state_d = RESET_PLL;
                clr     = 1'b1;
            end
        endcase
        cnt_d = clr ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= RESET_PLL;
            cnt_q               <= '0;
            sync_q              <= 2'b00;
            bus.pll_rst         <= 1'b1;
            bus.sys_reset       <= 1'b1;
            bus.ready           <= 1'b0;
            bus.fault           <= 1'b0;
            bus.retry_count     <= 4'd0;
            bus.lock_loss_count <= 8'd0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            sync_q              <= {sync_q[0], bus.pll_locked};
            // outputs decoded from the next state so they move with it
            bus.pll_rst         <= (state_d == RESET_PLL) ||
                                   (state_d == FAULT);
            bus.sys_reset       <= (state_d != RUN);
            bus.ready           <= (state_d == RUN);
            bus.fault           <= (state_d == FAULT);
            bus.retry_count     <= retry_d;
            bus.lock_loss_count <= llc_d;
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer with
// RST_PULSE=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2.
module tb_pll_reset_sequencer;
    logic refclk = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pll_reset_sequencer_if bus();

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_en) refclk = ~refclk;

    // {pll_rst, sys_reset, ready, fault}
    wire [3:0] flags = {bus.pll_rst, bus.sys_reset, bus.ready, bus.fault};

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic bring_up();
        apply_reset();
        tick(6);
        bus.pll_locked = 1'b1;
        tick(11);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        tick(3);
        n_tests++;
        if (flags !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp %b", flags, 4'b1100);
        end
        n_tests++;
        if (bus.retry_count !== 4'd0 || bus.lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counts got %0d/%0d exp 0/0",
                     bus.retry_count, bus.lock_loss_count);
        end
    endtask

    task automatic test_bringup();
        apply_reset();
        tick(3);
        n_tests++;
        if (flags !== 4'b1100) begin
            n_fail++;
            $display("FAIL bringup_e3 got %b exp %b", flags, 4'b1100);
        end
        tick(1);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL bringup_e4 got %b exp %b", flags, 4'b0100);
        end
        tick(2);
        bus.pll_locked = 1'b1;
        tick(10);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL bringup_e16 got %b exp %b", flags, 4'b0100);
        end
        tick(1);
        n_tests++;
        if (flags !== 4'b0010) begin
            n_fail++;
            $display("FAIL bringup_e17 got %b exp %b", flags, 4'b0010);
        end
        n_tests++;
        if (bus.retry_count !== 4'd0) begin
            n_fail++;
            $display("FAIL bringup_retry got %0d exp 0", bus.retry_count);
        end
    endtask

    task automatic test_no_lock();
        apply_reset();
        tick(35);
        n_tests++;
        if (bus.retry_count !== 4'd0) begin
            n_fail++;
            $display("FAIL nolock_e35 retry got %0d exp 0", bus.retry_count);
        end
        tick(1);
        n_tests++;
        if (bus.retry_count !== 4'd1 || flags !== 4'b1100) begin
            n_fail++;
            $display("FAIL nolock_e36 got retry %0d flags %b exp 1 1100",
                     bus.retry_count, flags);
        end
        tick(36);
        n_tests++;
        if (bus.retry_count !== 4'd2) begin
            n_fail++;
            $display("FAIL nolock_e72 retry got %0d exp 2", bus.retry_count);
        end
        tick(35);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL nolock_e107 got %b exp %b", flags, 4'b0100);
        end
        tick(1);
        n_tests++;
        if (flags !== 4'b1101 || bus.retry_count !== 4'd2) begin
            n_fail++;
            $display("FAIL nolock_fault got %b retry %0d exp 1101 2",
                     flags, bus.retry_count);
        end
        tick(20);
        n_tests++;
        if (flags !== 4'b1101 || bus.retry_count !== 4'd2) begin
            n_fail++;
            $display("FAIL nolock_fault_hold got %b retry %0d exp 1101 2",
                     flags, bus.retry_count);
        end
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        n_tests++;
        if (flags !== 4'b1100 || bus.retry_count !== 4'd0) begin
            n_fail++;
            $display("FAIL nolock_relock got %b retry %0d exp 1100 0",
                     flags, bus.retry_count);
        end
        tick(4);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL nolock_repulse got %b exp %b", flags, 4'b0100);
        end
    endtask

    task automatic test_lock_glitch();
        apply_reset();
        tick(6);
        bus.pll_locked = 1'b1;
        tick(7);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(2);
        n_tests++;
        if (flags !== 4'b0100 || bus.retry_count !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_e16 got %b retry %0d exp 0100 0",
                     flags, bus.retry_count);
        end
        tick(1);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL glitch_e17 got %b exp %b", flags, 4'b0100);
        end
        tick(7);
        n_tests++;
        if (flags !== 4'b0100) begin
            n_fail++;
            $display("FAIL glitch_e24 got %b exp %b", flags, 4'b0100);
        end
        tick(1);
        n_tests++;
        if (flags !== 4'b0010 || bus.retry_count !== 4'd0) begin
            n_fail++;
            $display("FAIL glitch_e25 got %b retry %0d exp 0010 0",
                     flags, bus.retry_count);
        end
    endtask

    // Starts in RUN with lock_loss_count == 0.
    task automatic test_lock_loss_saturate();
        for (int i = 0; i < 256; i++) begin
            bus.pll_locked = 1'b0;
            tick(2);
            n_tests++;
            if (flags !== 4'b0010) begin
                n_fail++;
                $display("FAIL loss%0d_j1 got %b exp %b", i, flags, 4'b0010);
            end
            tick(1);
            n_tests++;
            if (flags !== 4'b1100) begin
                n_fail++;
                $display("FAIL loss%0d_j2 got %b exp %b", i, flags, 4'b1100);
            end
            n_tests++;
            if (bus.lock_loss_count !== ((i >= 254) ? 8'd255 : 8'(i + 1))) begin
                n_fail++;
                $display("FAIL loss%0d_count got %0d exp %0d", i,
                         bus.lock_loss_count, (i >= 254) ? 255 : i + 1);
            end
            bus.pll_locked = 1'b1;
            tick(3);
            n_tests++;
            if (bus.pll_rst !== 1'b1) begin
                n_fail++;
                $display("FAIL loss%0d_pulse got %b exp 1", i, bus.pll_rst);
            end
            tick(1);
            n_tests++;
            if (flags !== 4'b0100) begin
                n_fail++;
                $display("FAIL loss%0d_j6 got %b exp %b", i, flags, 4'b0100);
            end
            tick(9);
            n_tests++;
            if (flags !== 4'b0010) begin
                n_fail++;
                $display("FAIL loss%0d_run got %b exp %b", i, flags, 4'b0010);
            end
        end
    endtask

    task automatic test_relock_vs_loss();
        bring_up();
        bus.pll_locked = 1'b0;
        tick(3);
        bus.pll_locked = 1'b1;
        tick(13);
        n_tests++;
        if (flags !== 4'b0010 || bus.lock_loss_count !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_setup got %b llc %0d exp 0010 1",
                     flags, bus.lock_loss_count);
        end
        bus.pll_locked = 1'b0;
        tick(2);
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        n_tests++;
        if (flags !== 4'b1100 || bus.lock_loss_count !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_prio got %b llc %0d exp 1100 1",
                     flags, bus.lock_loss_count);
        end
        bus.pll_locked = 1'b1;
        tick(13);
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        n_tests++;
        if (flags !== 4'b1100 || bus.lock_loss_count !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_run got %b llc %0d exp 1100 1",
                     flags, bus.lock_loss_count);
        end
    endtask

    task automatic test_async_reset();
        bring_up();
        bus.pll_locked = 1'b0;
        tick(3);
        tick(43);
        n_tests++;
        if (flags !== 4'b0100 || bus.retry_count !== 4'd1 ||
            bus.lock_loss_count !== 8'd1) begin
            n_fail++;
            $display("FAIL async_pre got %b retry %0d llc %0d exp 0100 1 1",
                     flags, bus.retry_count, bus.lock_loss_count);
        end
        clk_en = 1'b0;
        #30;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (flags !== 4'b1100 || bus.retry_count !== 4'd0 ||
            bus.lock_loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_rst got %b retry %0d llc %0d exp 1100 0 0",
                     flags, bus.retry_count, bus.lock_loss_count);
        end
        #30;
        clk_en = 1'b1;
    endtask

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        test_reset();
        test_bringup();
        test_no_lock();
        test_lock_glitch();
        test_lock_loss_saturate();
        test_relock_vs_loss();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
